alu_issue: RTL

//  Drives the ALU: decodes opcode/funct into the 4-bit ALU ctl code, picks operand B, and registers all ALU inputs.

---
 rtl/alu_issue_pkg.sv | 69 ++++++
 rtl/alu_issue_decode.sv | 91 +++++++++
 rtl/alu_issue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_pkg
// Description : Shared ALU control codes, MIPS opcode/funct values and
//               operand-forwarding helper for the ID/EX issue stage and ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    // ALU control codes
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;
    localparam logic [3:0] CTL_NOP = 4'b1111;   // ALU drives 0

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Operand bypass: MEM result beats WB result beats register file.
    // Register 0 is hard-wired to zero in the file, so it is never bypassed.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  idx,
        input logic [31:0] rf_data,
        input logic        mem_en,
        input logic [4:0]  mem_reg,
        input logic [31:0] mem_data,
        input logic        wb_en,
        input logic [4:0]  wb_reg,
        input logic [31:0] wb_data
    );
        logic [31:0] res;
        res = rf_data;
        if (idx != 5'd0) begin
            if (mem_en && (mem_reg == idx)) begin
                res = mem_data;
            end else if (wb_en && (wb_reg == idx)) begin
                res = wb_data;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode
// Description : Combinational opcode/funct decoder producing the ALU control
//               code and the operand/destination selects for the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ctl_o,
    output logic       use_imm_o,     // B comes from the immediate
    output logic       zero_ext_o,    // immediate is zero- rather than sign-extended
    output logic       wr_rd_sel_o,   // destination is rd (else rt)
    output logic       wr_en_o,       // instruction class writes a register
    output logic       illegal_o
);

    // Decode table; anything not listed falls through to the illegal response.
    always_comb begin
        ctl_o       = CTL_NOP;
        use_imm_o   = 1'b0;
        zero_ext_o  = 1'b0;
        wr_rd_sel_o = 1'b0;
        wr_en_o     = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                wr_rd_sel_o = 1'b1;
                wr_en_o     = 1'b1;
                case (funct_i)
                    FN_ADD, FN_ADDU: ctl_o = CTL_ADD;
                    FN_SUB, FN_SUBU: ctl_o = CTL_SUB;
                    FN_AND:          ctl_o = CTL_AND;
                    FN_OR:           ctl_o = CTL_OR;
                    FN_XOR:          ctl_o = CTL_XOR;
                    FN_NOR:          ctl_o = CTL_NOR;
                    FN_SLT:          ctl_o = CTL_SLT;
                    default: begin
                        ctl_o       = CTL_NOP;
                        wr_rd_sel_o = 1'b0;
                        wr_en_o     = 1'b0;
                        illegal_o   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                ctl_o     = CTL_ADD;
                use_imm_o = 1'b1;
                wr_en_o   = 1'b1;
            end
            OP_SLTI: begin
                ctl_o     = CTL_SLT;
                use_imm_o = 1'b1;
                wr_en_o   = 1'b1;
            end
            OP_SW: begin
                ctl_o     = CTL_ADD;
                use_imm_o = 1'b1;
            end
            OP_ANDI: begin
                ctl_o      = CTL_AND;
                use_imm_o  = 1'b1;
                zero_ext_o = 1'b1;
                wr_en_o    = 1'b1;
            end
            OP_ORI: begin
                ctl_o      = CTL_OR;
                use_imm_o  = 1'b1;
                zero_ext_o = 1'b1;
                wr_en_o    = 1'b1;
            end
            OP_XORI: begin
                ctl_o      = CTL_XOR;
                use_imm_o  = 1'b1;
                zero_ext_o = 1'b1;
                wr_en_o    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctl_o = CTL_SUB;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : ID/EX pipeline register for the ALU. Decodes opcode/funct,
//               bypasses MEM/WB results onto rs/rt, extends the immediate,
//               selects operand B and registers everything with stall/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN     = 32,   // only 32 is supported
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [5:0]          id_opcode,
    input  logic [5:0]          id_funct,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic [15:0]         id_imm,
    input  logic [XLEN-1:0]     id_rs_data,
    input  logic [XLEN-1:0]     id_rt_data,
    input  logic                stall,
    input  logic                flush,
    input  logic                mem_wr_en,
    input  logic [REG_BITS-1:0] mem_wr_reg,
    input  logic [XLEN-1:0]     mem_wr_data,
    input  logic                wb_wr_en,
    input  logic [REG_BITS-1:0] wb_wr_reg,
    input  logic [XLEN-1:0]     wb_wr_data,
    output logic                ex_valid,
    output logic [3:0]          ex_ctl,
    output logic [XLEN-1:0]     ex_a,
    output logic [XLEN-1:0]     ex_b,
    output logic                ex_wr_en,
    output logic [REG_BITS-1:0] ex_wr_reg,
    output logic                ex_illegal
);

    logic [3:0]          dec_ctl;
    logic                dec_use_imm;
    logic                dec_zero_ext;
    logic                dec_wr_rd_sel;
    logic                dec_wr_en;
    logic                dec_illegal;

    logic [XLEN-1:0]     rs_fwd;
    logic [XLEN-1:0]     rt_fwd;
    logic [XLEN-1:0]     imm_ext;
    logic [XLEN-1:0]     opb;
    logic [REG_BITS-1:0] dst;

    logic                valid_q,   valid_d;
    logic [3:0]          ctl_q,     ctl_d;
    logic [XLEN-1:0]     a_q,       a_d;
    logic [XLEN-1:0]     b_q,       b_d;
    logic                wr_en_q,   wr_en_d;
    logic [REG_BITS-1:0] wr_reg_q,  wr_reg_d;
    logic                illegal_q, illegal_d;

    alu_decode u_decode (
        .opcode_i    (id_opcode),
        .funct_i     (id_funct),
        .ctl_o       (dec_ctl),
        .use_imm_o   (dec_use_imm),
        .zero_ext_o  (dec_zero_ext),
        .wr_rd_sel_o (dec_wr_rd_sel),
        .wr_en_o     (dec_wr_en),
        .illegal_o   (dec_illegal)
    );

    // Operand bypass, immediate extension, B select and destination select.
    always_comb begin
        rs_fwd  = fwd_operand(id_rs, id_rs_data, mem_wr_en, mem_wr_reg, mem_wr_data,
                              wb_wr_en, wb_wr_reg, wb_wr_data);
        rt_fwd  = fwd_operand(id_rt, id_rt_data, mem_wr_en, mem_wr_reg, mem_wr_data,
                              wb_wr_en, wb_wr_reg, wb_wr_data);
        imm_ext = dec_zero_ext ? {{(XLEN-16){1'b0}}, id_imm}
                               : {{(XLEN-16){id_imm[15]}}, id_imm};
        opb     = dec_use_imm ? imm_ext : rt_fwd;
        // Illegal instructions get no destination so nothing downstream can write.
        if (dec_illegal) begin
            dst = '0;
        end else if (dec_wr_rd_sel) begin
            dst = id_rd;
        end else begin
            dst = id_rt;
        end
    end

    // EX register next state: flush beats stall beats load; an empty slot loads a bubble.
    always_comb begin
        valid_d   = valid_q;
        ctl_d     = ctl_q;
        a_d       = a_q;
        b_d       = b_q;
        wr_en_d   = wr_en_q;
        wr_reg_d  = wr_reg_q;
        illegal_d = illegal_q;
        if (flush || (!stall && !id_valid)) begin
            valid_d   = 1'b0;
            ctl_d     = CTL_NOP;
            a_d       = '0;
            b_d       = '0;
            wr_en_d   = 1'b0;
            wr_reg_d  = '0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            valid_d   = 1'b1;
            ctl_d     = dec_ctl;
            a_d       = rs_fwd;
            b_d       = opb;
            wr_en_d   = dec_wr_en && (dst != '0);
            wr_reg_d  = dst;
            illegal_d = dec_illegal;
        end
    end

    // EX register; reset forces a bubble immediately, discarding any held instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctl_q     <= CTL_NOP;
            a_q       <= '0;
            b_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctl_q     <= ctl_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctl     = ctl_q;
    assign ex_a       = a_q;
    assign ex_b       = b_q;
    assign ex_wr_en   = wr_en_q;
    assign ex_wr_reg  = wr_reg_q;
    assign ex_illegal = illegal_q;

endmodule
`default_nettype wire
